// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : load-use / branch / jump / halt interlock for the 5-stage core
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_func,
  input  logic             id_jump,
  input  logic [4:0]       ex_rw,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  logic [0:0] state;
  logic [0:0] state_nxt;

  logic uses_rs;
  logic uses_rt;
  logic rtype_uses_rt;
  logic load_use;

  logic ev_stall;
  logic ev_flush;
  logic ev_cycle;

  // Source-operand decode of the instruction sitting in ID.
  always_comb begin
    uses_rs = (id_op != OP_J) && (id_op != OP_JAL);
  end

  always_comb begin
    rtype_uses_rt = 1'b0;
    case (id_func)
      FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SLTU, FN_SYSCALL: rtype_uses_rt = 1'b1;
      default:                             rtype_uses_rt = 1'b0;
    endcase
  end

  always_comb begin
    uses_rt = 1'b0;
    case (id_op)
      OP_RTYPE:                     uses_rt = rtype_uses_rt;
      OP_SW, OP_SH, OP_BEQ, OP_BNE: uses_rt = 1'b1;
      default:                      uses_rt = 1'b0;
    endcase
  end

  always_comb begin
    load_use = ex_memread && (ex_rw != 5'd0) &&
               ((uses_rs && (ex_rw == id_rs)) || (uses_rt && (ex_rw == id_rt)));
  end

  // Control outputs and counter events; branch outranks load-use because the
  // instruction in ID is then on the wrong path.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    halted    = 1'b0;
    ev_stall  = 1'b0;
    ev_flush  = 1'b0;
    ev_cycle  = 1'b0;
    state_nxt = state;

    if (rst) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          ev_cycle = 1'b1;
          if (ex_halt) begin
            idex_clr  = 1'b1;
            state_nxt = S_HALT;
          end else if (ex_branch_taken) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            ev_flush = 1'b1;
          end else if (load_use) begin
            idex_clr = 1'b1;
            ev_stall = 1'b1;
          end else if (id_jump) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            ifid_clr = 1'b1;
            ev_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end

        S_HALT: begin
          idex_clr = 1'b1;
          halted   = 1'b1;
          if (resume) begin
            state_nxt = S_RUN;
          end
        end

        default: begin
          state_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (ev_stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ev_flush) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (ev_cycle) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the 5-stage MIPS core. It covers the hazards that the forwarding unit cannot resolve. It detects load-use dependences between the ID and EX stages and inserts one bubble. It flushes wrong-path instructions on taken branches and jumps, and holds the core in a halt state after a terminating syscall. It drives the PC and IF/ID enables plus the IF/ID and ID/EX clears, and keeps per-event performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_op  in  6  opcode of instruction in ID
- id_func  in  6  funct field of instruction in ID
- id_jump  in  1  ID holds j/jal (target resolved in ID)
- ex_rw  in  5  destination register of instruction in EX
- ex_memread  in  1  EX instruction is a load (lw/lb/lbu/lh/lhu)
- ex_branch_taken  in  1  EX holds beq/bne whose condition is true
- ex_halt  in  1  EX holds syscall with halt condition met
- resume  in  1  single-cycle pulse, leave HALT
- pc_en  out  1  PC register write enable
- ifid_en  out  1  IF/ID register write enable
- ifid_clr  out  1  IF/ID synchronous clear (insert nop)
- idex_clr  out  1  ID/EX synchronous clear (insert bubble)
- halted  out  1  high while in HALT
- stall_cnt  out  CNT_W  number of load-use bubbles inserted
- flush_cnt  out  CNT_W  number of branch/jump flush events
- cycle_cnt  out  CNT_W  cycles spent in RUN

## Operation
- Source usage is decoded from id_op/id_func.
  - uses_rs: every opcode except j (0x02) and jal (0x03).
  - uses_rt: R-type add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2a, sltu 0x2b, syscall 0x0c; I-type sw 0x2b, sh 0x29, beq 0x04, bne 0x05.
- load_use = ex_memread && ex_rw!=0 && ((uses_rs && ex_rw==id_rs) || (uses_rt && ex_rw==id_rt)).
- States: RUN, HALT. The reset state is RUN.
- RUN: RUN→HALT on ex_halt. The PC freezes the same cycle. Instructions already past EX complete normally.
- HALT: HALT→RUN on resume. resume is ignored in RUN.
- Priority in RUN, highest first:
  1. ex_halt: pc_en=0, ifid_en=0, idex_clr=1.
  2. ex_branch_taken: pc_en=1, ifid_clr=1, idex_clr=1; flush_cnt+1. A simultaneous load_use is dropped because the ID instruction is wrong-path.
  3. load_use: pc_en=0, ifid_en=0, idex_clr=1; stall_cnt+1.
  4. id_jump: pc_en=1, ifid_clr=1; flush_cnt+1.
  5. Otherwise: pc_en=1, ifid_en=1, all clears 0.
- HALT: pc_en=0, ifid_en=0, ifid_clr=0, idex_clr=1 (no new work enters EX), halted=1.
- Counters wrap modulo 2^CNT_W. cycle_cnt increments on every clock in RUN, including stall and flush cycles. No counter increments in HALT.

## Timing
- All control outputs are combinational from the current inputs and the state register. Counters and state update on the next rising edge.
- A load-use stall lasts exactly one cycle: after the bubble enters EX, ex_memread=0, so load_use deasserts naturally. No state is held for it.
- rst high: state←RUN and all counters←0 on the edge. While rst is high, pc_en=0, ifid_en=0, ifid_clr=1, idex_clr=1, halted=0.
- Reset mid-stall or in HALT returns to RUN with zero counters. The first non-reset cycle uses normal RUN decoding.
- ex_halt and resume in the same cycle while in RUN: enter HALT (resume ignored).
- resume and a new ex_halt in HALT: cannot occur, because EX is cleared.

## Test plan
- Dependent load: lw $2 in EX (ex_memread=1, ex_rw=2), add $3,$2,$4 in ID → one cycle with pc_en=0, ifid_en=0, idex_clr=1, stall_cnt 0→1. The next cycle has pc_en=1.
- Non-dependent loads:
  - ex_rw=0 with id_rs=0 → no stall.
  - addi in ID with rt==ex_rw, load in EX → no stall, since rt is not a source for addi.
  - sw in ID with rt==ex_rw → stall.
- Branch over stall: ex_branch_taken=1 and load_use=1 in the same cycle → pc_en=1, ifid_clr=1, idex_clr=1, flush_cnt+1, stall_cnt unchanged.
- Jump: id_jump=1 alone → ifid_clr=1, idex_clr=0, flush_cnt+1.
- Halt/resume: ex_halt pulse → halted=1 next cycle, with pc_en=0 held. Hold 10 cycles: cycle_cnt frozen. resume pulse → RUN and pc_en=1 the following cycle.
- Reset: assert rst during HALT with nonzero counters → next cycle state RUN, all counters 0. During rst, pc_en=0 and both clears are 1.
